npi_arb2: RTL and testbench
===========================

Name: npi_arb2

Overview:
- Two-master arbiter sharing one MPMC NPI port (PI_*) between two requesters, e.g. the SATA DMA engine and a second NPI client.
- Sits between the requesters and the MPMC port.
- Round-robin ownership of the address phase; write-FIFO push access follows the address-phase owner.
- Read returns are steered to the issuing master through an in-order tag FIFO.

Parameters:
- C_TAG_DEPTH, 4, max outstanding (address-acked, not fully popped) read bursts; power of 2, 2..16.
- C_PI_ADDR_WIDTH, 32, NPI address width.
- C_PI_DATA_WIDTH, 32, NPI data width; only 32 supported.

Ports:
- MPMC_Clk  in  1  sole clock
- MPMC_Rst  in  1  asynchronous, active-high reset
- Mn_AddrReq  in  1  master n (n=0,1) request; held until Mn_AddrAck
- Mn_Addr  in  32  master n burst address
- Mn_RNW  in  1  master n: 1=read, 0=write
- Mn_Size  in  4  master n NPI size code
- Mn_AddrAck  out  1  master n address accepted
- Mn_Gnt  out  1  master n owns address phase and write-FIFO push
- Mn_WrFIFO_Data / _BE / _Push  in  32/4/1  master n write data; used only while Mn_Gnt=1
- Mn_RdFIFO_Empty  out  1  master n view of read FIFO
- Mn_RdFIFO_Pop  in  1  master n pop
- Mn_RdFIFO_Data  out  32  PI_RdFIFO_Data broadcast to both masters
- PI_Addr / PI_AddrReq / PI_RNW / PI_Size  out  32/1/1/4  to MPMC
- PI_RdModWr  out  1  constant 0
- PI_AddrAck / PI_InitDone  in  1/1  from MPMC
- PI_WrFIFO_Data / _BE / _Push  out  32/4/1  muxed from owner
- PI_WrFIFO_AlmostFull  in  1  forwarded unchanged to both masters as Mn_WrFIFO_AlmostFull (out, 1)
- PI_RdFIFO_Empty  in  1
- PI_RdFIFO_Pop  out  1

Behaviour:
- Reset values:
  - all Mn_Gnt, Mn_AddrAck, PI_AddrReq, PI_WrFIFO_Push, PI_RdFIFO_Pop = 0
  - Mn_RdFIFO_Empty = 1; tag FIFO empty; last-owner pointer = 1 (so M0 wins first)
- Arbiter FSM: IDLE, OWN0, OWN1, ACK.
- IDLE:
  - no grant while PI_InitDone=0.
  - A master is eligible if Mn_AddrReq=1 and (Mn_RNW=0 or tag FIFO not full).
  - One eligible master -> OWNn next cycle.
  - Both eligible -> the master other than the last owner.
  - Grant is registered, so Mn_Gnt rises 1 cycle after the request is seen.
- OWNn:
  - Mn_Gnt=1.
  - Mn_WrFIFO_* routed to PI_WrFIFO_*; non-owner pushes are dropped.
  - PI_AddrReq = Mn_AddrReq (combinational passthrough with Addr/RNW/Size).
  - Master pushes all write data before raising AddrReq (NPI rule); the arbiter does not check this.
  - If Mn_AddrReq drops before ack -> IDLE, no owner change recorded.
- PI_AddrAck=1 in OWNn:
  - Mn_AddrAck pulses 1 cycle, combinational from PI_AddrAck.
  - If read: push tag {n, Size}.
  - Update last owner = n; -> ACK.
- ACK: one dead cycle (Gnt=0, PI_AddrReq=0) so the master can drop its request -> IDLE. Minimum request-to-request spacing is 3 cycles.
- Read steering:
  - Head tag selects owner h.
  - Mh_RdFIFO_Empty = PI_RdFIFO_Empty; the other master sees Empty=1.
  - PI_RdFIFO_Pop = Mh_RdFIFO_Pop & ~PI_RdFIFO_Empty; non-head pops ignored.
  - Tag FIFO empty -> both Empty=1, Pop=0.
- Word counter (7-bit) loads the burst length when the tag reaches head: Size 0->1, 1->4, 2->8, 3->16, 4->32, 5->64 words; other codes treated as 1.
- Counter decrements per effective pop; when it reaches 0 (after the last pop) the tag is popped and the next tag loads on the following cycle.
- Tag push and pop in the same cycle are legal; count is unchanged.
- Tag FIFO full: read requests are ineligible, writes proceed.
- Reset mid-burst clears tags and the FSM; PI_*_Flush is not driven (tied 0); the system resets MPMC concurrently.

Optional Feature:
- Macro NPI_ARB2_PERF_EN.
- When defined: outputs Perf_Gnt0, Perf_Gnt1 (16 bits each) and Perf_Stall (16 bits).
  - Perf_Gntn: saturating count of Mn_AddrAck pulses.
  - Perf_Stall: saturating count of cycles where some Mn_AddrReq=1 and the FSM is IDLE with no eligible master.
  - All cleared by MPMC_Rst.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- PI_InitDone=0, M0 read req held 20 cycles -> no Gnt, no PI_AddrReq; raise InitDone -> M0_Gnt 1 cycle later.
- M0 and M1 write req same cycle from reset, each acked -> order M0, M1, M0, M1 across 4 requests each; M1 pushes while M0 owns are absent on PI_WrFIFO_Push.
- M0 read Size=1 then M1 read Size=2, PI_RdFIFO_Empty=0 -> M0 receives exactly 4 pops with M1_RdFIFO_Empty=1; then M1 receives 8 pops; tag FIFO empty afterward.
- C_TAG_DEPTH=4: 4 acked M0 reads, no pops, M1 write + M0 read pending -> M1 write granted, M0 read stalls until first burst fully popped.
- M1 pops during M0 head burst -> PI_RdFIFO_Pop stays 0, counter unchanged.
- Assert MPMC_Rst during OWN1 with 2 tags pending -> next cycle all outputs at reset values, M*_RdFIFO_Empty=1.

Source files
------------

// File: rtl/npi_arb2.sv
// npi_arb2: two-master round-robin arbiter onto one MPMC NPI port, with in-order read-return steering.
// Optional performance counters are compiled in when NPI_ARB2_PERF_EN is defined.
module npi_arb2 #(
  parameter int C_TAG_DEPTH     = 4,
  parameter int C_PI_ADDR_WIDTH = 32,
  parameter int C_PI_DATA_WIDTH = 32
) (
  input  logic                         MPMC_Clk,
  input  logic                         MPMC_Rst,
  input  logic                         M0_AddrReq,
  input  logic [C_PI_ADDR_WIDTH-1:0]   M0_Addr,
  input  logic                         M0_RNW,
  input  logic [3:0]                   M0_Size,
  output logic                         M0_AddrAck,
  output logic                         M0_Gnt,
  input  logic [C_PI_DATA_WIDTH-1:0]   M0_WrFIFO_Data,
  input  logic [C_PI_DATA_WIDTH/8-1:0] M0_WrFIFO_BE,
  input  logic                         M0_WrFIFO_Push,
  output logic                         M0_WrFIFO_AlmostFull,
  output logic                         M0_RdFIFO_Empty,
  input  logic                         M0_RdFIFO_Pop,
  output logic [C_PI_DATA_WIDTH-1:0]   M0_RdFIFO_Data,
  input  logic                         M1_AddrReq,
  input  logic [C_PI_ADDR_WIDTH-1:0]   M1_Addr,
  input  logic                         M1_RNW,
  input  logic [3:0]                   M1_Size,
  output logic                         M1_AddrAck,
  output logic                         M1_Gnt,
  input  logic [C_PI_DATA_WIDTH-1:0]   M1_WrFIFO_Data,
  input  logic [C_PI_DATA_WIDTH/8-1:0] M1_WrFIFO_BE,
  input  logic                         M1_WrFIFO_Push,
  output logic                         M1_WrFIFO_AlmostFull,
  output logic                         M1_RdFIFO_Empty,
  input  logic                         M1_RdFIFO_Pop,
  output logic [C_PI_DATA_WIDTH-1:0]   M1_RdFIFO_Data,
  output logic [C_PI_ADDR_WIDTH-1:0]   PI_Addr,
  output logic                         PI_AddrReq,
  output logic                         PI_RNW,
  output logic [3:0]                   PI_Size,
  output logic                         PI_RdModWr,
  input  logic                         PI_AddrAck,
  input  logic                         PI_InitDone,
  output logic [C_PI_DATA_WIDTH-1:0]   PI_WrFIFO_Data,
  output logic [C_PI_DATA_WIDTH/8-1:0] PI_WrFIFO_BE,
  output logic                         PI_WrFIFO_Push,
  input  logic                         PI_WrFIFO_AlmostFull,
  output logic                         PI_WrFIFO_Flush,
  input  logic                         PI_RdFIFO_Empty,
  output logic                         PI_RdFIFO_Pop,
  input  logic [C_PI_DATA_WIDTH-1:0]   PI_RdFIFO_Data,
  output logic                         PI_RdFIFO_Flush
`ifdef NPI_ARB2_PERF_EN
  ,
  output logic [15:0]                  Perf_Gnt0,
  output logic [15:0]                  Perf_Gnt1,
  output logic [15:0]                  Perf_Stall
`endif
);

  localparam int TAG_AW = (C_TAG_DEPTH > 1) ? $clog2(C_TAG_DEPTH) : 1;
  localparam logic [TAG_AW:0] TAG_FULL = (TAG_AW+1)'(C_TAG_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_OWN0, ST_OWN1, ST_ACK} state_t;

  function automatic logic [6:0] burst_len(input logic [3:0] size);
    case (size)
      4'd1:    burst_len = 7'd4;
      4'd2:    burst_len = 7'd8;
      4'd3:    burst_len = 7'd16;
      4'd4:    burst_len = 7'd32;
      4'd5:    burst_len = 7'd64;
      default: burst_len = 7'd1;
    endcase
  endfunction

  state_t            state_q;
  logic              gnt0_q, gnt1_q;
  logic              last_q;
  logic [TAG_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [TAG_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TAG_AW:0]   tag_cnt_q, tag_cnt_d;
  logic              head_vld_q, head_vld_d;
  logic [6:0]        wcnt_q, wcnt_d;
  logic [4:0]        tag_mem_q [C_TAG_DEPTH];

  logic       tag_full, tag_empty;
  logic       elig0, elig1;
  logic       ack0, ack1;
  logic       tag_push, tag_pop, rd_pop;
  logic [4:0] tag_din, head_tag;
  logic       head_m;

  assign tag_full  = (tag_cnt_q == TAG_FULL);
  assign tag_empty = (tag_cnt_q == '0);

  // A read is only eligible while there is room to remember where its data goes.
  assign elig0 = M0_AddrReq & (~M0_RNW | ~tag_full);
  assign elig1 = M1_AddrReq & (~M1_RNW | ~tag_full);

  assign M0_Gnt = gnt0_q;
  assign M1_Gnt = gnt1_q;

  assign PI_AddrReq = (gnt0_q & M0_AddrReq) | (gnt1_q & M1_AddrReq);
  assign PI_Addr    = gnt1_q ? M1_Addr : M0_Addr;
  assign PI_RNW     = gnt1_q ? M1_RNW  : M0_RNW;
  assign PI_Size    = gnt1_q ? M1_Size : M0_Size;
  assign PI_RdModWr = 1'b0;

  assign ack0       = gnt0_q & M0_AddrReq & PI_AddrAck;
  assign ack1       = gnt1_q & M1_AddrReq & PI_AddrAck;
  assign M0_AddrAck = ack0;
  assign M1_AddrAck = ack1;

  assign PI_WrFIFO_Data  = gnt1_q ? M1_WrFIFO_Data : M0_WrFIFO_Data;
  assign PI_WrFIFO_BE    = gnt1_q ? M1_WrFIFO_BE   : M0_WrFIFO_BE;
  assign PI_WrFIFO_Push  = (gnt0_q & M0_WrFIFO_Push) | (gnt1_q & M1_WrFIFO_Push);
  assign PI_WrFIFO_Flush = 1'b0;
  assign PI_RdFIFO_Flush = 1'b0;

  assign M0_WrFIFO_AlmostFull = PI_WrFIFO_AlmostFull;
  assign M1_WrFIFO_AlmostFull = PI_WrFIFO_AlmostFull;
  assign M0_RdFIFO_Data       = PI_RdFIFO_Data;
  assign M1_RdFIFO_Data       = PI_RdFIFO_Data;

  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) begin
      state_q <= ST_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (PI_InitDone) begin
            if (elig0 & (~elig1 | last_q)) begin
              state_q <= ST_OWN0;
              gnt0_q  <= 1'b1;
            end else if (elig1) begin
              state_q <= ST_OWN1;
              gnt1_q  <= 1'b1;
            end
          end
        end
        ST_OWN0: begin
          if (ack0) begin
            state_q <= ST_ACK;
            gnt0_q  <= 1'b0;
            last_q  <= 1'b0;
          end else if (!M0_AddrReq) begin
            state_q <= ST_IDLE;
            gnt0_q  <= 1'b0;
          end
        end
        ST_OWN1: begin
          if (ack1) begin
            state_q <= ST_ACK;
            gnt1_q  <= 1'b0;
            last_q  <= 1'b1;
          end else if (!M1_AddrReq) begin
            state_q <= ST_IDLE;
            gnt1_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
      endcase
    end
  end

  // Tag = {issuing master, size}; the head tag owns the shared read FIFO until its burst is drained.
  assign tag_push = (ack0 & M0_RNW) | (ack1 & M1_RNW);
  assign tag_din  = ack1 ? {1'b1, M1_Size} : {1'b0, M0_Size};
  assign head_tag = tag_mem_q[rd_ptr_q];
  assign head_m   = head_tag[4];

  assign M0_RdFIFO_Empty = ~(head_vld_q & ~head_m) | PI_RdFIFO_Empty;
  assign M1_RdFIFO_Empty = ~(head_vld_q &  head_m) | PI_RdFIFO_Empty;
  assign rd_pop          = head_vld_q & ~PI_RdFIFO_Empty & (head_m ? M1_RdFIFO_Pop : M0_RdFIFO_Pop);
  assign PI_RdFIFO_Pop   = rd_pop;
  assign tag_pop         = rd_pop & (wcnt_q == 7'd1);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_cnt_d  = tag_cnt_q;
    head_vld_d = head_vld_q;
    wcnt_d     = wcnt_q;
    if (tag_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (tag_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({tag_push, tag_pop})
      2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
      2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
      default: tag_cnt_d = tag_cnt_q;
    endcase
    // The word counter loads one cycle after a tag reaches the head.
    if (!head_vld_q) begin
      if (!tag_empty) begin
        head_vld_d = 1'b1;
        wcnt_d     = burst_len(head_tag[3:0]);
      end
    end else if (rd_pop) begin
      wcnt_d = wcnt_q - 7'd1;
      if (wcnt_q == 7'd1) head_vld_d = 1'b0;
    end
  end

  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_cnt_q  <= '0;
      head_vld_q <= 1'b0;
      wcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_cnt_q  <= tag_cnt_d;
      head_vld_q <= head_vld_d;
      wcnt_q     <= wcnt_d;
    end
  end

  always_ff @(posedge MPMC_Clk) begin
    if (tag_push) tag_mem_q[wr_ptr_q] <= tag_din;
  end

`ifdef NPI_ARB2_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] perf_gnt0_q, perf_gnt1_q, perf_stall_q;
  logic        stall;

  // Someone is asking but nobody can be granted (tag FIFO full for reads).
  assign stall = (M0_AddrReq | M1_AddrReq) & (state_q == ST_IDLE) & ~elig0 & ~elig1;

  always_ff @(posedge MPMC_Clk or posedge MPMC_Rst) begin
    if (MPMC_Rst) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (ack0)  perf_gnt0_q  <= sat_inc(perf_gnt0_q);
      if (ack1)  perf_gnt1_q  <= sat_inc(perf_gnt1_q);
      if (stall) perf_stall_q <= sat_inc(perf_stall_q);
    end
  end

  assign Perf_Gnt0  = perf_gnt0_q;
  assign Perf_Gnt1  = perf_gnt1_q;
  assign Perf_Stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_npi_arb2.sv
// Directed bench for npi_arb2: arbitration order, InitDone gating, read steering, tag-full stall, reset.
module tb_npi_arb2;

  logic        clk = 1'b0;
  logic        MPMC_Rst;
  logic        M0_AddrReq, M1_AddrReq, M0_RNW, M1_RNW;
  logic [31:0] M0_Addr, M1_Addr;
  logic [3:0]  M0_Size, M1_Size;
  logic        M0_AddrAck, M1_AddrAck, M0_Gnt, M1_Gnt;
  logic [31:0] M0_WrFIFO_Data, M1_WrFIFO_Data;
  logic [3:0]  M0_WrFIFO_BE, M1_WrFIFO_BE;
  logic        M0_WrFIFO_Push, M1_WrFIFO_Push;
  logic        M0_WrFIFO_AlmostFull, M1_WrFIFO_AlmostFull;
  logic        M0_RdFIFO_Empty, M1_RdFIFO_Empty, M0_RdFIFO_Pop, M1_RdFIFO_Pop;
  logic [31:0] M0_RdFIFO_Data, M1_RdFIFO_Data;
  logic [31:0] PI_Addr;
  logic        PI_AddrReq, PI_RNW, PI_RdModWr, PI_AddrAck, PI_InitDone;
  logic [3:0]  PI_Size;
  logic [31:0] PI_WrFIFO_Data;
  logic [3:0]  PI_WrFIFO_BE;
  logic        PI_WrFIFO_Push, PI_WrFIFO_AlmostFull, PI_WrFIFO_Flush;
  logic        PI_RdFIFO_Empty, PI_RdFIFO_Pop, PI_RdFIFO_Flush;
  logic [31:0] PI_RdFIFO_Data;
`ifdef NPI_ARB2_PERF_EN
  logic [15:0] Perf_Gnt0, Perf_Gnt1, Perf_Stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  npi_arb2 #(.C_TAG_DEPTH(4), .C_PI_ADDR_WIDTH(32), .C_PI_DATA_WIDTH(32)) dut (
    .MPMC_Clk(clk), .MPMC_Rst(MPMC_Rst),
    .M0_AddrReq(M0_AddrReq), .M0_Addr(M0_Addr), .M0_RNW(M0_RNW), .M0_Size(M0_Size),
    .M0_AddrAck(M0_AddrAck), .M0_Gnt(M0_Gnt),
    .M0_WrFIFO_Data(M0_WrFIFO_Data), .M0_WrFIFO_BE(M0_WrFIFO_BE), .M0_WrFIFO_Push(M0_WrFIFO_Push),
    .M0_WrFIFO_AlmostFull(M0_WrFIFO_AlmostFull), .M0_RdFIFO_Empty(M0_RdFIFO_Empty),
    .M0_RdFIFO_Pop(M0_RdFIFO_Pop), .M0_RdFIFO_Data(M0_RdFIFO_Data),
    .M1_AddrReq(M1_AddrReq), .M1_Addr(M1_Addr), .M1_RNW(M1_RNW), .M1_Size(M1_Size),
    .M1_AddrAck(M1_AddrAck), .M1_Gnt(M1_Gnt),
    .M1_WrFIFO_Data(M1_WrFIFO_Data), .M1_WrFIFO_BE(M1_WrFIFO_BE), .M1_WrFIFO_Push(M1_WrFIFO_Push),
    .M1_WrFIFO_AlmostFull(M1_WrFIFO_AlmostFull), .M1_RdFIFO_Empty(M1_RdFIFO_Empty),
    .M1_RdFIFO_Pop(M1_RdFIFO_Pop), .M1_RdFIFO_Data(M1_RdFIFO_Data),
    .PI_Addr(PI_Addr), .PI_AddrReq(PI_AddrReq), .PI_RNW(PI_RNW), .PI_Size(PI_Size),
    .PI_RdModWr(PI_RdModWr), .PI_AddrAck(PI_AddrAck), .PI_InitDone(PI_InitDone),
    .PI_WrFIFO_Data(PI_WrFIFO_Data), .PI_WrFIFO_BE(PI_WrFIFO_BE), .PI_WrFIFO_Push(PI_WrFIFO_Push),
    .PI_WrFIFO_AlmostFull(PI_WrFIFO_AlmostFull), .PI_WrFIFO_Flush(PI_WrFIFO_Flush),
    .PI_RdFIFO_Empty(PI_RdFIFO_Empty), .PI_RdFIFO_Pop(PI_RdFIFO_Pop),
    .PI_RdFIFO_Data(PI_RdFIFO_Data), .PI_RdFIFO_Flush(PI_RdFIFO_Flush)
`ifdef NPI_ARB2_PERF_EN
    , .Perf_Gnt0(Perf_Gnt0), .Perf_Gnt1(Perf_Gnt1), .Perf_Stall(Perf_Stall)
`endif
  );

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Drives one full request/grant/ack handshake for master m; ok=0 if no grant within max_wait cycles.
  task automatic do_req(input int m, input logic rnw, input logic [3:0] size, input int max_wait,
                        output bit ok);
    int n;
    n = 0;
    if (m == 0) begin
      M0_AddrReq = 1'b1; M0_RNW = rnw; M0_Size = size; M0_Addr = 32'h1000_0000 | 32'(size);
    end else begin
      M1_AddrReq = 1'b1; M1_RNW = rnw; M1_Size = size; M1_Addr = 32'h2000_0000 | 32'(size);
    end
    step();
    while (!((m == 0) ? M0_Gnt : M1_Gnt) && n < max_wait) begin
      step();
      n++;
    end
    ok = (m == 0) ? M0_Gnt : M1_Gnt;
    if (ok) begin
      PI_AddrAck = 1'b1;
      step();
      PI_AddrAck = 1'b0;
    end
    if (m == 0) M0_AddrReq = 1'b0;
    else        M1_AddrReq = 1'b0;
    step();
  endtask

  task automatic test_reset();
    MPMC_Rst = 1'b1;
    PI_RdFIFO_Empty = 1'b0; M0_RdFIFO_Pop = 1'b1; M1_RdFIFO_Pop = 1'b1;
    M0_WrFIFO_Push = 1'b1; M1_WrFIFO_Push = 1'b1;
    PI_WrFIFO_AlmostFull = 1'b1; PI_RdFIFO_Data = 32'h1234_5678;
    step(); step();
    checks++;
    if ({M0_Gnt, M1_Gnt, M0_AddrAck, M1_AddrAck} !== 4'b0000)
      begin errors++; $display("FAIL rst_gnt_ack got %b expected 0000", {M0_Gnt, M1_Gnt, M0_AddrAck, M1_AddrAck}); end
    checks++;
    if ({PI_AddrReq, PI_WrFIFO_Push, PI_RdFIFO_Pop} !== 3'b000)
      begin errors++; $display("FAIL rst_pi got %b expected 000", {PI_AddrReq, PI_WrFIFO_Push, PI_RdFIFO_Pop}); end
    checks++;
    if ({M0_RdFIFO_Empty, M1_RdFIFO_Empty} !== 2'b11)
      begin errors++; $display("FAIL rst_empty got %b expected 11", {M0_RdFIFO_Empty, M1_RdFIFO_Empty}); end
    checks++;
    if ({M0_WrFIFO_AlmostFull, M1_WrFIFO_AlmostFull} !== 2'b11 || M0_RdFIFO_Data !== 32'h1234_5678 ||
        M1_RdFIFO_Data !== 32'h1234_5678)
      begin errors++; $display("FAIL rst_fwd got af=%b d0=%h d1=%h expected af=11 d=12345678",
        {M0_WrFIFO_AlmostFull, M1_WrFIFO_AlmostFull}, M0_RdFIFO_Data, M1_RdFIFO_Data); end
    checks++;
    if ({PI_RdModWr, PI_WrFIFO_Flush, PI_RdFIFO_Flush} !== 3'b000)
      begin errors++; $display("FAIL rst_ties got %b expected 000", {PI_RdModWr, PI_WrFIFO_Flush, PI_RdFIFO_Flush}); end
    PI_RdFIFO_Empty = 1'b1; M0_RdFIFO_Pop = 1'b0; M1_RdFIFO_Pop = 1'b0;
    M0_WrFIFO_Push = 1'b0; M1_WrFIFO_Push = 1'b0; PI_WrFIFO_AlmostFull = 1'b0;
    MPMC_Rst = 1'b0;
    step();
  endtask

  task automatic test_init_done();
    int bad;
    bad = 0;
    PI_InitDone = 1'b0;
    M0_AddrReq = 1'b1; M0_RNW = 1'b1; M0_Size = 4'd0; M0_Addr = 32'hCAFE_0000;
    for (int i = 0; i < 20; i++) begin
      step();
      if (M0_Gnt || M1_Gnt || PI_AddrReq) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL init_block got %0d grant cycles expected 0", bad); end
    PI_InitDone = 1'b1;
    step();
    checks++;
    if (M0_Gnt !== 1'b1 || M1_Gnt !== 1'b0)
      begin errors++; $display("FAIL init_gnt got %b%b expected 10", M0_Gnt, M1_Gnt); end
    checks++;
    if (PI_AddrReq !== 1'b1 || PI_RNW !== 1'b1 || PI_Addr !== 32'hCAFE_0000)
      begin errors++; $display("FAIL init_pass got req=%b rnw=%b addr=%h expected 1 1 cafe0000", PI_AddrReq, PI_RNW, PI_Addr); end
    M0_AddrReq = 1'b0;
    #1;
    checks++;
    if (PI_AddrReq !== 1'b0) begin errors++; $display("FAIL init_req_drop got %b expected 0", PI_AddrReq); end
    step();
    checks++;
    if (M0_Gnt !== 1'b0) begin errors++; $display("FAIL init_release got %b expected 0", M0_Gnt); end
  endtask

  task automatic test_round_robin();
    int rem0, rem1, n, got;
    rem0 = 4; rem1 = 4;
    M0_RNW = 1'b0; M1_RNW = 1'b0;
    M0_AddrReq = 1'b1; M1_AddrReq = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      step();
      while (!M0_Gnt && !M1_Gnt && n < 10) begin step(); n++; end
      got = M0_Gnt ? 0 : (M1_Gnt ? 1 : -1);
      checks++;
      if (got !== (i % 2)) begin errors++; $display("FAIL rr_order[%0d] got %0d expected %0d", i, got, i % 2); end
      if (got == 0) begin
        M1_WrFIFO_Push = 1'b1; M1_WrFIFO_Data = 32'hBBBB_0000 + 32'(i);
        #1;
        checks++;
        if (PI_WrFIFO_Push !== 1'b0) begin errors++; $display("FAIL rr_drop_m1[%0d] got %b expected 0", i, PI_WrFIFO_Push); end
        M0_WrFIFO_Push = 1'b1; M0_WrFIFO_Data = 32'hAAAA_0000 + 32'(i); M0_WrFIFO_BE = 4'h5;
        #1;
        checks++;
        if (PI_WrFIFO_Push !== 1'b1 || PI_WrFIFO_Data !== 32'hAAAA_0000 + 32'(i) || PI_WrFIFO_BE !== 4'h5)
          begin errors++; $display("FAIL rr_push_m0[%0d] got %b %h %h expected 1 %h 5", i, PI_WrFIFO_Push,
            PI_WrFIFO_Data, PI_WrFIFO_BE, 32'hAAAA_0000 + 32'(i)); end
      end else if (got == 1) begin
        M0_WrFIFO_Push = 1'b1; M0_WrFIFO_Data = 32'hAAAA_0000 + 32'(i);
        #1;
        checks++;
        if (PI_WrFIFO_Push !== 1'b0) begin errors++; $display("FAIL rr_drop_m0[%0d] got %b expected 0", i, PI_WrFIFO_Push); end
        M1_WrFIFO_Push = 1'b1; M1_WrFIFO_Data = 32'hBBBB_0000 + 32'(i); M1_WrFIFO_BE = 4'hA;
        #1;
        checks++;
        if (PI_WrFIFO_Push !== 1'b1 || PI_WrFIFO_Data !== 32'hBBBB_0000 + 32'(i) || PI_WrFIFO_BE !== 4'hA)
          begin errors++; $display("FAIL rr_push_m1[%0d] got %b %h %h expected 1 %h a", i, PI_WrFIFO_Push,
            PI_WrFIFO_Data, PI_WrFIFO_BE, 32'hBBBB_0000 + 32'(i)); end
      end
      M0_WrFIFO_Push = 1'b0; M1_WrFIFO_Push = 1'b0;
      PI_AddrAck = 1'b1;
      #1;
      checks++;
      if ({M0_AddrAck, M1_AddrAck} !== ((got == 0) ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL rr_ack[%0d] got %b expected %b", i, {M0_AddrAck, M1_AddrAck}, (got == 0) ? 2'b10 : 2'b01); end
      step();
      PI_AddrAck = 1'b0;
      if (got == 0) begin M0_AddrReq = 1'b0; rem0--; end
      else          begin M1_AddrReq = 1'b0; rem1--; end
      step();
      if (got == 0 && rem0 > 0) M0_AddrReq = 1'b1;
      if (got == 1 && rem1 > 0) M1_AddrReq = 1'b1;
    end
    M0_AddrReq = 1'b0; M1_AddrReq = 1'b0;
    step();
  endtask

  task automatic test_read_steering();
    bit ok;
    int pops, early, vis;
    PI_RdFIFO_Empty = 1'b1;
    do_req(0, 1'b1, 4'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL steer_req0 got 0 expected 1"); end
    do_req(1, 1'b1, 4'd2, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL steer_req1 got 0 expected 1"); end
    PI_RdFIFO_Empty = 1'b0; M0_RdFIFO_Pop = 1'b1;
    pops = 0; early = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (!M1_RdFIFO_Empty && pops < 4) early++;
      if (PI_RdFIFO_Pop) pops++;
      step();
    end
    checks++;
    if (pops !== 4) begin errors++; $display("FAIL steer_m0_pops got %0d expected 4", pops); end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL steer_m1_hidden got %0d visible cycles expected 0", early); end
    checks++;
    if ({M0_RdFIFO_Empty, M1_RdFIFO_Empty} !== 2'b10)
      begin errors++; $display("FAIL steer_handover got %b expected 10", {M0_RdFIFO_Empty, M1_RdFIFO_Empty}); end
    M0_RdFIFO_Pop = 1'b0; M1_RdFIFO_Pop = 1'b1;
    pops = 0; vis = 0;
    for (int i = 0; i < 14; i++) begin
      #1;
      if (!M0_RdFIFO_Empty) vis++;
      if (PI_RdFIFO_Pop) pops++;
      step();
    end
    checks++;
    if (pops !== 8) begin errors++; $display("FAIL steer_m1_pops got %0d expected 8", pops); end
    checks++;
    if (vis !== 0) begin errors++; $display("FAIL steer_m0_hidden got %0d visible cycles expected 0", vis); end
    M0_RdFIFO_Pop = 1'b1;
    #1;
    checks++;
    if ({M0_RdFIFO_Empty, M1_RdFIFO_Empty, PI_RdFIFO_Pop} !== 3'b110)
      begin errors++; $display("FAIL steer_drained got %b expected 110", {M0_RdFIFO_Empty, M1_RdFIFO_Empty, PI_RdFIFO_Pop}); end
    M0_RdFIFO_Pop = 1'b0; M1_RdFIFO_Pop = 1'b0; PI_RdFIFO_Empty = 1'b1;
    step();
  endtask

  task automatic test_nonhead_pop();
    bit ok;
    int pops, vis;
    PI_RdFIFO_Empty = 1'b1;
    do_req(0, 1'b1, 4'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL nonhead_req got 0 expected 1"); end
    PI_RdFIFO_Empty = 1'b0; M1_RdFIFO_Pop = 1'b1;
    pops = 0; vis = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (PI_RdFIFO_Pop) pops++;
      if (!M0_RdFIFO_Empty) vis++;
      step();
    end
    checks++;
    if (pops !== 0) begin errors++; $display("FAIL nonhead_ignored got %0d pops expected 0", pops); end
    checks++;
    if (vis !== 6) begin errors++; $display("FAIL nonhead_m0_view got %0d expected 6", vis); end
    M1_RdFIFO_Pop = 1'b0; M0_RdFIFO_Pop = 1'b1;
    pops = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (PI_RdFIFO_Pop) pops++;
      step();
    end
    checks++;
    if (pops !== 4) begin errors++; $display("FAIL nonhead_count_kept got %0d pops expected 4", pops); end
    M0_RdFIFO_Pop = 1'b0; PI_RdFIFO_Empty = 1'b1;
    step();
  endtask

  task automatic test_size_default();
    bit ok;
    int pops;
    do_req(1, 1'b1, 4'd9, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL size9_req got 0 expected 1"); end
    PI_RdFIFO_Empty = 1'b0; M1_RdFIFO_Pop = 1'b1;
    pops = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (PI_RdFIFO_Pop) pops++;
      step();
    end
    checks++;
    if (pops !== 1) begin errors++; $display("FAIL size9_pops got %0d expected 1", pops); end
    M1_RdFIFO_Pop = 1'b0; PI_RdFIFO_Empty = 1'b1;
    step();
  endtask

  task automatic test_tag_full();
    bit ok;
    int n, bad, pops;
    PI_RdFIFO_Empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 1'b1, 4'd0, 10, ok);
      checks++; if (!ok) begin errors++; $display("FAIL full_fill[%0d] got 0 expected 1", i); end
    end
    M1_RNW = 1'b0; M1_AddrReq = 1'b1;
    M0_RNW = 1'b1; M0_Size = 4'd0; M0_AddrReq = 1'b1;
    n = 0;
    step();
    while (!M0_Gnt && !M1_Gnt && n < 10) begin step(); n++; end
    checks++;
    if ({M0_Gnt, M1_Gnt} !== 2'b01) begin errors++; $display("FAIL full_write_gnt got %b expected 01", {M0_Gnt, M1_Gnt}); end
    checks++;
    if (PI_AddrReq !== 1'b1 || PI_RNW !== 1'b0)
      begin errors++; $display("FAIL full_write_pi got req=%b rnw=%b expected 1 0", PI_AddrReq, PI_RNW); end
    PI_AddrAck = 1'b1;
    step();
    PI_AddrAck = 1'b0; M1_AddrReq = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (M0_Gnt || PI_AddrReq) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL full_read_stall got %0d grant cycles expected 0", bad); end
    PI_RdFIFO_Empty = 1'b0; M0_RdFIFO_Pop = 1'b1;
    #1;
    checks++;
    if (PI_RdFIFO_Pop !== 1'b1) begin errors++; $display("FAIL full_first_pop got %b expected 1", PI_RdFIFO_Pop); end
    step();
    PI_RdFIFO_Empty = 1'b1; M0_RdFIFO_Pop = 1'b0;
    n = 0;
    while (!M0_Gnt && n < 5) begin step(); n++; end
    checks++;
    if (M0_Gnt !== 1'b1) begin errors++; $display("FAIL full_read_resume got %b expected 1", M0_Gnt); end
    PI_AddrAck = 1'b1;
    step();
    PI_AddrAck = 1'b0; M0_AddrReq = 1'b0;
    step();
    PI_RdFIFO_Empty = 1'b0; M0_RdFIFO_Pop = 1'b1;
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (PI_RdFIFO_Pop) pops++;
      step();
    end
    checks++;
    if (pops !== 4) begin errors++; $display("FAIL full_drain got %0d pops expected 4", pops); end
    M0_RdFIFO_Pop = 1'b0; PI_RdFIFO_Empty = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int n;
    PI_RdFIFO_Empty = 1'b1;
    do_req(0, 1'b1, 4'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_req_a got 0 expected 1"); end
    do_req(0, 1'b1, 4'd1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_req_b got 0 expected 1"); end
    M1_RNW = 1'b0; M1_AddrReq = 1'b1;
    n = 0;
    step();
    while (!M1_Gnt && n < 10) begin step(); n++; end
    checks++;
    if (M1_Gnt !== 1'b1) begin errors++; $display("FAIL rmid_own1 got %b expected 1", M1_Gnt); end
    M1_WrFIFO_Push = 1'b1; PI_RdFIFO_Empty = 1'b0; M0_RdFIFO_Pop = 1'b1;
    MPMC_Rst = 1'b1;
    step();
    checks++;
    if ({M0_Gnt, M1_Gnt, PI_AddrReq, PI_WrFIFO_Push, PI_RdFIFO_Pop} !== 5'b00000)
      begin errors++; $display("FAIL rmid_outputs got %b expected 00000",
        {M0_Gnt, M1_Gnt, PI_AddrReq, PI_WrFIFO_Push, PI_RdFIFO_Pop}); end
    checks++;
    if ({M0_RdFIFO_Empty, M1_RdFIFO_Empty} !== 2'b11)
      begin errors++; $display("FAIL rmid_empty got %b expected 11", {M0_RdFIFO_Empty, M1_RdFIFO_Empty}); end
    MPMC_Rst = 1'b0; M1_AddrReq = 1'b0; M1_WrFIFO_Push = 1'b0;
    step(); step();
    checks++;
    if ({M0_RdFIFO_Empty, PI_RdFIFO_Pop} !== 2'b10)
      begin errors++; $display("FAIL rmid_tags_cleared got %b expected 10", {M0_RdFIFO_Empty, PI_RdFIFO_Pop}); end
    M0_RdFIFO_Pop = 1'b0; PI_RdFIFO_Empty = 1'b1;
    M0_RNW = 1'b0; M0_AddrReq = 1'b1; M1_AddrReq = 1'b1;
    step();
    checks++;
    if ({M0_Gnt, M1_Gnt} !== 2'b10) begin errors++; $display("FAIL rmid_last_reset got %b expected 10", {M0_Gnt, M1_Gnt}); end
    M0_AddrReq = 1'b0; M1_AddrReq = 1'b0;
    step(); step();
  endtask

  initial begin
    MPMC_Rst = 1'b1;
    M0_AddrReq = 1'b0; M1_AddrReq = 1'b0; M0_RNW = 1'b0; M1_RNW = 1'b0;
    M0_Addr = '0; M1_Addr = '0; M0_Size = '0; M1_Size = '0;
    M0_WrFIFO_Data = '0; M1_WrFIFO_Data = '0; M0_WrFIFO_BE = '0; M1_WrFIFO_BE = '0;
    M0_WrFIFO_Push = 1'b0; M1_WrFIFO_Push = 1'b0;
    M0_RdFIFO_Pop = 1'b0; M1_RdFIFO_Pop = 1'b0;
    PI_AddrAck = 1'b0; PI_InitDone = 1'b0; PI_WrFIFO_AlmostFull = 1'b0;
    PI_RdFIFO_Empty = 1'b1; PI_RdFIFO_Data = '0;
    test_reset();
    test_init_done();
    test_round_robin();
    test_read_steering();
    test_nonhead_pop();
    test_size_default();
    test_tag_full();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
